// File: rtl/seq_mul.sv
// -----------------------------------------------------------------------------
// seq_mul
//   Sequential unsigned shift-add multiplier. One partial product per clock is
//   added into the upper half of a 2*WIDTH accumulator, which then shifts right
//   by one with the adder carry entering the MSB. WIDTH iterations produce the
//   exact 2*WIDTH-bit product.
//
// Handshake (valid/ready style, single comment for the whole block):
//   start_i is the request. It is accepted only when the block is IDLE, i.e.
//   busy_o=0 and done_o=0 on the sampling edge. a_i/b_i are latched on that
//   edge, so later changes have no effect. A start seen in RUN or DONE is
//   dropped, not queued. done_o is a one-cycle pulse; product_o holds the last
//   completed product until the next completion or a reset.
//
// Ports:
//   clk_i      in   1        clock, rising edge
//   rst_i      in   1        asynchronous, active-high reset
//   start_i    in   1        operation request (sampled only in IDLE)
//   a_i        in   WIDTH    multiplicand
//   b_i        in   WIDTH    multiplier
//   busy_o     out  1        high while iterating (state RUN)
//   done_o     out  1        completion pulse (state DONE)
//   product_o  out  2*WIDTH  last completed product
//
// Build option:
//   SEQ_MUL_ZERO_SKIP_EN  when defined, a start with a zero operand goes
//                         straight to DONE with product 0 (latency 1 edge).
// -----------------------------------------------------------------------------
module seq_mul #(
    parameter int WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   product_o
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state_q;
    logic [WIDTH-1:0]       mcand_q;
    logic [WIDTH-1:0]       mplr_q;
    logic [2*WIDTH-1:0]     acc_q;
    logic [CW-1:0]          cnt_q;
    logic                   busy_q;
    logic                   done_q;
    logic [2*WIDTH-1:0]     product_q;

    // Datapath for one iteration.
    logic [WIDTH-1:0]       pp_d;
    logic [WIDTH:0]         sum_d;
    logic [2*WIDTH-1:0]     acc_d;

    assign pp_d  = mcand_q & {WIDTH{mplr_q[0]}};
    // Carry is kept: the upper half plus the partial product needs WIDTH+1 bits.
    assign sum_d = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, pp_d};
    // Concatenate sum over the lower half, then drop the LSB: a right shift by
    // one with the carry landing in the accumulator MSB.
    assign acc_d = (2*WIDTH)'({sum_d, acc_q[WIDTH-1:0]} >> 1);

`ifdef SEQ_MUL_ZERO_SKIP_EN
    logic zero_op;
    assign zero_op = (a_i == '0) || (b_i == '0);
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            mplr_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
`ifdef SEQ_MUL_ZERO_SKIP_EN
                        if (zero_op) begin
                            product_q <= '0;
                            state_q   <= S_DONE;
                            done_q    <= 1'b1;
                        end else begin
                            mcand_q <= a_i;
                            mplr_q  <= b_i;
                            acc_q   <= '0;
                            cnt_q   <= '0;
                            state_q <= S_RUN;
                            busy_q  <= 1'b1;
                        end
`else
                        mcand_q <= a_i;
                        mplr_q  <= b_i;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
`endif
                    end
                end
                S_RUN: begin
                    acc_q  <= acc_d;
                    mplr_q <= mplr_q >> 1;
                    cnt_q  <= cnt_q + CW'(1);
                    if (cnt_q == LAST_CNT) begin
                        product_q <= acc_d;
                        state_q   <= S_DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign product_o = product_q;

endmodule

// File: tb/tb_seq_mul.sv
module tb_seq_mul;

    localparam int W = 32;
`ifdef SEQ_MUL_ZERO_SKIP_EN
    localparam bit ZERO_SKIP = 1'b1;
`else
    localparam bit ZERO_SKIP = 1'b0;
`endif

    logic           clk;
    logic           rst_i;
    logic           start_i;
    logic [W-1:0]   a_i;
    logic [W-1:0]   b_i;
    logic           busy_o;
    logic           done_o;
    logic [2*W-1:0] product_o;

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    seq_mul #(.WIDTH(W)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .a_i       (a_i),
        .b_i       (b_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .product_o (product_o)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver ----------------
    // Issues one start and observes the DUT until one edge after done_o.
    // k counts edges after the accepting edge E0 (k=0 is just after E0).
    // inj: k at which a stray start (a=2,b=2) is raised; -1 for none.
    // inj_done: also raise a stray start while done_o is high.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int inj, input bit inj_done,
                          output int lat, output int busy_n, output int done_n,
                          output bit overlap, output bit prod_moved,
                          output logic [2*W-1:0] prod);
        logic [2*W-1:0] p0;
        p0 = product_o;
        lat = -1; busy_n = 0; done_n = 0; overlap = 1'b0; prod_moved = 1'b0;
        a_i = a; b_i = b; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        a_i = $urandom; b_i = $urandom;
        for (int k = 0; k < W + 6; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            if (busy_o) busy_n++;
            if (done_o) begin
                done_n++;
                if (lat < 0) lat = k;
            end
            if (busy_o && done_o) overlap = 1'b1;
            if (busy_o && (product_o !== p0)) prod_moved = 1'b1;
            start_i = 1'b0;
            if (k == inj || (inj_done && done_o)) begin
                start_i = 1'b1; a_i = 2; b_i = 2;
            end
            if (lat >= 0 && k == lat + 1) break;
        end
        start_i = 1'b0;
        prod = product_o;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst_i = 1'b1; start_i = 1'b0; a_i = '0; b_i = '0;
        #3;
        n_checks++;
        if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b exp 0", busy_o); else n_pass++;
        n_checks++;
        if (done_o !== 1'b0) $display("FAIL reset_done: got %b exp 0", done_o); else n_pass++;
        n_checks++;
        if (product_o !== 64'h0) $display("FAIL reset_product: got %h exp 0", product_o); else n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
    endtask

    task automatic test_basic;
        int lat, bn, dn; bit ov, pm; logic [2*W-1:0] p;
        run_op(32'd3, 32'd5, -1, 1'b0, lat, bn, dn, ov, pm, p);
        n_checks++;
        if (p !== 64'h0000_0000_0000_000F) $display("FAIL basic_product: got %h exp f", p); else n_pass++;
        n_checks++;
        if (lat !== W) $display("FAIL basic_latency: got %0d exp %0d", lat, W); else n_pass++;
        n_checks++;
        if (bn !== W) $display("FAIL basic_busy_cycles: got %0d exp %0d", bn, W); else n_pass++;
        n_checks++;
        if (dn !== 1) $display("FAIL basic_done_pulses: got %0d exp 1", dn); else n_pass++;
        n_checks++;
        if (ov !== 1'b0) $display("FAIL basic_busy_done_overlap: got %b exp 0", ov); else n_pass++;
        n_checks++;
        if (pm !== 1'b0) $display("FAIL basic_product_stable: got %b exp 0", pm); else n_pass++;
    endtask

    task automatic test_max;
        int lat, bn, dn; bit ov, pm; logic [2*W-1:0] p;
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0, lat, bn, dn, ov, pm, p);
        n_checks++;
        if (p !== 64'hFFFF_FFFE_0000_0001) $display("FAIL max_product: got %h exp fffffffe00000001", p); else n_pass++;
        n_checks++;
        if (lat !== W) $display("FAIL max_latency: got %0d exp %0d", lat, W); else n_pass++;
    endtask

    task automatic test_ignored_start;
        int lat, bn, dn; bit ov, pm; logic [2*W-1:0] p;
        run_op(32'd7, 32'd9, 10, 1'b1, lat, bn, dn, ov, pm, p);
        n_checks++;
        if (p !== 64'd63) $display("FAIL ignore_product: got %0d exp 63", p); else n_pass++;
        n_checks++;
        if (dn !== 1) $display("FAIL ignore_done_pulses: got %0d exp 1", dn); else n_pass++;
        n_checks++;
        if (bn !== W) $display("FAIL ignore_busy_cycles: got %0d exp %0d", bn, W); else n_pass++;
        n_checks++;
        if (lat !== W) $display("FAIL ignore_latency: got %0d exp %0d", lat, W); else n_pass++;
    endtask

    task automatic test_abort_reset;
        int lat, bn, dn; bit ov, pm; logic [2*W-1:0] p;
        bit activity;
        a_i = 32'h1234; b_i = 32'h5678; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (14) @(posedge clk);
        #2 rst_i = 1'b1;
        #1;
        n_checks++;
        if (busy_o !== 1'b0) $display("FAIL abort_busy: got %b exp 0", busy_o); else n_pass++;
        n_checks++;
        if (done_o !== 1'b0) $display("FAIL abort_done: got %b exp 0", done_o); else n_pass++;
        n_checks++;
        if (product_o !== 64'h0) $display("FAIL abort_product: got %h exp 0", product_o); else n_pass++;
        @(negedge clk);
        rst_i = 1'b0;
        activity = 1'b0;
        for (int k = 0; k < W + 4; k++) begin
            @(posedge clk); #1;
            if (busy_o || done_o || product_o !== 64'h0) activity = 1'b1;
        end
        n_checks++;
        if (activity !== 1'b0) $display("FAIL abort_quiet: got %b exp 0", activity); else n_pass++;
        run_op(32'd6, 32'd7, -1, 1'b0, lat, bn, dn, ov, pm, p);
        n_checks++;
        if (p !== 64'd42) $display("FAIL abort_next_product: got %0d exp 42", p); else n_pass++;
    endtask

    task automatic test_zero;
        int lat, bn, dn; bit ov, pm; logic [2*W-1:0] p;
        int exp_lat;
        exp_lat = ZERO_SKIP ? 0 : W;
        run_op(32'd0, 32'hDEAD, -1, 1'b0, lat, bn, dn, ov, pm, p);
        n_checks++;
        if (p !== 64'h0) $display("FAIL zero_product: got %h exp 0", p); else n_pass++;
        n_checks++;
        if (lat !== exp_lat) $display("FAIL zero_latency: got %0d exp %0d", lat, exp_lat); else n_pass++;
        n_checks++;
        if (bn !== exp_lat) $display("FAIL zero_busy_cycles: got %0d exp %0d", bn, exp_lat); else n_pass++;
        n_checks++;
        if (dn !== 1) $display("FAIL zero_done_pulses: got %0d exp 1", dn); else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] exp_q_a[$];
        logic [W-1:0] exp_q_b[$];
        int lat, bn, dn; bit ov, pm; logic [2*W-1:0] p;
        logic [W-1:0] a, b;
        logic [2*W-1:0] exp_p;
        int exp_lat;
        for (int i = 0; i < 200; i++) begin
            exp_q_a.push_back($urandom);
            exp_q_b.push_back($urandom);
        end
        for (int i = 0; i < 200; i++) begin
            a = exp_q_a.pop_front();
            b = exp_q_b.pop_front();
            exp_p = {32'h0, a} * {32'h0, b};
            exp_lat = (ZERO_SKIP && (a == 0 || b == 0)) ? 0 : W;
            // run_op returns one edge after done_o, so the next start lands on
            // the earliest edge at which the DUT is back in IDLE.
            run_op(a, b, -1, 1'b0, lat, bn, dn, ov, pm, p);
            n_checks++;
            if (p !== exp_p) $display("FAIL b2b_product[%0d]: a=%h b=%h got %h exp %h", i, a, b, p, exp_p); else n_pass++;
            n_checks++;
            if (lat !== exp_lat) $display("FAIL b2b_latency[%0d]: got %0d exp %0d", i, lat, exp_lat); else n_pass++;
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_basic();
        test_max();
        test_ignored_start();
        test_abort_reset();
        test_zero();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
